// File: rtl/gpsreceiver2_capture_ctl.sv
// ---------------------------------------------------------------------------
// gpsreceiver2_capture_ctl
//
// Capture sequencer for the GPS-SDR sample buffer. A start command arms the
// sequencer, which optionally waits for a 1PPS rising edge and then drives
// the external sample-address counter (r_enable / r_reset) and the buffer
// write port for blocks of length+1 samples, single-shot or as a ring.
//
// Ports
//   rxb0_clk, rxb0_rst_n   receiver clock, synchronous active-low reset
//   start, abort           one-cycle commands (abort has priority)
//   continuous             0 = single-shot, 1 = ring mode (latched on start)
//   use_trigger            wait for 1PPS rising edge (latched on start)
//   trigger                1PPS level, already synchronous to rxb0_clk
//   length                 last address of a block (latched on start)
//   sample_valid           ADC sample strobe
//   irq_ack                one-cycle interrupt clear
//   r_enable, r_reset      increment / clear strobes to the address counter
//   rxb0_we, rxb0_adr      buffer write port
//   busy                   state is ARMED or CAPTURE
//   irq, overrun           sticky block-complete / lost-interrupt flags
//   block_count            completed blocks since the last start (wraps)
//   state                  current FSM state
//
// state   | meaning
// --------+---------------------------------------------------------------
// IDLE    | waiting for start; no writes
// ARMED   | config latched, counter cleared; waiting for trigger (if used)
// CAPTURE | each sample_valid produces one write on the next cycle
// DONE    | single-shot block finished; waiting for a new start
// ---------------------------------------------------------------------------
module gpsreceiver2_capture_ctl #(
    parameter int DEPTH_LOG2 = 11
) (
    input  logic                  rxb0_clk,
    input  logic                  rxb0_rst_n,
    input  logic                  start,
    input  logic                  abort,
    input  logic                  continuous,
    input  logic                  use_trigger,
    input  logic                  trigger,
    input  logic [DEPTH_LOG2-1:0] length,
    input  logic                  sample_valid,
    input  logic                  irq_ack,
    output logic                  r_enable,
    output logic                  r_reset,
    output logic                  rxb0_we,
    output logic [DEPTH_LOG2-1:0] rxb0_adr,
    output logic                  busy,
    output logic                  irq,
    output logic                  overrun,
    output logic [15:0]           block_count,
    output logic [1:0]            state
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARMED   = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_DONE    = 2'd3
    } state_t;

    localparam logic [DEPTH_LOG2-1:0] CNT_ONE = DEPTH_LOG2'(1);

    // registered state
    state_t                r_state;
    logic [DEPTH_LOG2-1:0] r_cnt;
    logic [DEPTH_LOG2-1:0] r_len_l;
    logic                  r_cont_l;
    logic                  r_use_trig_l;
    logic                  r_trig_prev;

    // next-state values
    state_t                w_state_nxt;
    logic [DEPTH_LOG2-1:0] w_cnt_nxt;
    logic [DEPTH_LOG2-1:0] w_len_nxt;
    logic                  w_cont_nxt;
    logic                  w_use_trig_nxt;
    logic                  w_trig_edge;
    logic                  w_enable_nxt;
    logic                  w_reset_nxt;
    logic                  w_we_nxt;
    logic [DEPTH_LOG2-1:0] w_adr_nxt;
    logic                  w_busy_nxt;
    logic                  w_irq_set;
    logic                  w_irq_nxt;
    logic                  w_overrun_nxt;
    logic [15:0]           w_block_count_nxt;

    assign state = r_state;

    // -----------------------------------------------------------------------
    // Next-state and next-output logic
    // -----------------------------------------------------------------------
    always_comb begin
        w_state_nxt       = r_state;
        w_cnt_nxt         = r_cnt;
        w_len_nxt         = r_len_l;
        w_cont_nxt        = r_cont_l;
        w_use_trig_nxt    = r_use_trig_l;
        w_enable_nxt      = 1'b0;
        w_reset_nxt       = 1'b0;
        w_we_nxt          = 1'b0;
        w_adr_nxt         = rxb0_adr;
        w_irq_set         = 1'b0;
        w_overrun_nxt     = overrun;
        w_block_count_nxt = block_count;

        w_trig_edge = trigger & ~r_trig_prev;

        if (abort) begin
            // abort beats every other command and suppresses all strobes
            w_state_nxt = ST_IDLE;
        end else begin
            unique case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        w_len_nxt         = length;
                        w_cont_nxt        = continuous;
                        w_use_trig_nxt    = use_trigger;
                        w_cnt_nxt         = '0;
                        w_overrun_nxt     = 1'b0;
                        w_block_count_nxt = 16'd0;
                        w_reset_nxt       = 1'b1;
                        w_state_nxt       = ST_ARMED;
                    end
                end

                ST_ARMED: begin
                    // samples arriving here are dropped, even on the edge cycle
                    if (!r_use_trig_l || w_trig_edge) begin
                        w_state_nxt = ST_CAPTURE;
                    end
                end

                ST_CAPTURE: begin
                    if (sample_valid) begin
                        w_we_nxt  = 1'b1;
                        w_adr_nxt = r_cnt;
                        if (r_cnt != r_len_l) begin
                            w_enable_nxt = 1'b1;
                            w_cnt_nxt    = r_cnt + CNT_ONE;
                        end else begin
                            // block end: clear the external counter in step
                            // with our own so both point at address 0 next
                            w_reset_nxt       = 1'b1;
                            w_cnt_nxt         = '0;
                            w_block_count_nxt = block_count + 16'd1;
                            w_irq_set         = 1'b1;
                            if (irq) begin
                                w_overrun_nxt = 1'b1;
                            end
                            if (!r_cont_l) begin
                                w_state_nxt = ST_DONE;
                            end
                        end
                    end
                end

                default: begin
                    w_state_nxt = ST_IDLE;
                end
            endcase
        end

        // a new block end outranks a simultaneous acknowledge
        if (w_irq_set) begin
            w_irq_nxt = 1'b1;
        end else if (irq_ack) begin
            w_irq_nxt = 1'b0;
        end else begin
            w_irq_nxt = irq;
        end

        w_busy_nxt = (w_state_nxt == ST_ARMED) || (w_state_nxt == ST_CAPTURE);
    end

    // -----------------------------------------------------------------------
    // State and output registers
    // -----------------------------------------------------------------------
    always_ff @(posedge rxb0_clk) begin
        if (!rxb0_rst_n) begin
            r_state      <= ST_IDLE;
            r_cnt        <= '0;
            r_len_l      <= '0;
            r_cont_l     <= 1'b0;
            r_use_trig_l <= 1'b0;
            r_trig_prev  <= 1'b0;
            r_enable     <= 1'b0;
            r_reset      <= 1'b0;
            rxb0_we      <= 1'b0;
            rxb0_adr     <= '0;
            busy         <= 1'b0;
            irq          <= 1'b0;
            overrun      <= 1'b0;
            block_count  <= 16'd0;
        end else begin
            r_state      <= w_state_nxt;
            r_cnt        <= w_cnt_nxt;
            r_len_l      <= w_len_nxt;
            r_cont_l     <= w_cont_nxt;
            r_use_trig_l <= w_use_trig_nxt;
            r_trig_prev  <= trigger;
            r_enable     <= w_enable_nxt;
            r_reset      <= w_reset_nxt;
            rxb0_we      <= w_we_nxt;
            rxb0_adr     <= w_adr_nxt;
            busy         <= w_busy_nxt;
            irq          <= w_irq_nxt;
            overrun      <= w_overrun_nxt;
            block_count  <= w_block_count_nxt;
        end
    end

endmodule

// File: tb/tb_gpsreceiver2_capture_ctl.sv
// ---------------------------------------------------------------------------
// Bench for gpsreceiver2_capture_ctl. Inputs change on the falling edge,
// outputs are sampled on the falling edge. The reference model tracks the
// number of samples written since start and derives address, block count
// and block ends from that count arithmetically.
// ---------------------------------------------------------------------------
module tb_gpsreceiver2_capture_ctl;

    localparam int DL = 11;

    logic          rxb0_clk = 1'b0;
    logic          rxb0_rst_n;
    logic          start, abort, continuous, use_trigger, trigger;
    logic [DL-1:0] length;
    logic          sample_valid, irq_ack;
    logic          r_enable, r_reset, rxb0_we, busy, irq, overrun;
    logic [DL-1:0] rxb0_adr;
    logic [15:0]   block_count;
    logic [1:0]    state;

    int n_cmp = 0;
    int n_err = 0;

    gpsreceiver2_capture_ctl #(.DEPTH_LOG2(DL)) dut (
        .rxb0_clk    (rxb0_clk),
        .rxb0_rst_n  (rxb0_rst_n),
        .start       (start),
        .abort       (abort),
        .continuous  (continuous),
        .use_trigger (use_trigger),
        .trigger     (trigger),
        .length      (length),
        .sample_valid(sample_valid),
        .irq_ack     (irq_ack),
        .r_enable    (r_enable),
        .r_reset     (r_reset),
        .rxb0_we     (rxb0_we),
        .rxb0_adr    (rxb0_adr),
        .busy        (busy),
        .irq         (irq),
        .overrun     (overrun),
        .block_count (block_count),
        .state       (state)
    );

    always #5 rxb0_clk = ~rxb0_clk;

    // ---------------- reference model ----------------
    // m_mode: 0 idle, 1 armed, 2 capturing, 3 done
    int m_mode = 0, m_len = 0, m_wcount = 0, m_adr = 0, m_bc = 0;
    bit m_cont = 0, m_trig = 0, m_tprev = 0;
    bit m_en = 0, m_rst = 0, m_we = 0, m_busy = 0, m_irq = 0, m_ovr = 0;
    bit m_edge, m_set;
    int m_pos;

    always @(posedge rxb0_clk) begin
        if (!rxb0_rst_n) begin
            m_mode = 0; m_len = 0; m_wcount = 0; m_adr = 0; m_bc = 0;
            m_cont = 0; m_trig = 0; m_tprev = 0;
            m_en = 0; m_rst = 0; m_we = 0; m_busy = 0; m_irq = 0; m_ovr = 0;
        end else begin
            m_edge = trigger && !m_tprev;
            m_tprev = trigger;
            m_en = 0; m_rst = 0; m_we = 0; m_set = 0;
            if (abort) begin
                m_mode = 0;
            end else if ((m_mode == 0 || m_mode == 3) && start) begin
                m_len = int'(length); m_cont = continuous; m_trig = use_trigger;
                m_wcount = 0; m_bc = 0; m_ovr = 0; m_rst = 1; m_mode = 1;
            end else if (m_mode == 1) begin
                if (!m_trig || m_edge) m_mode = 2;
            end else if (m_mode == 2 && sample_valid) begin
                m_pos = m_wcount % (m_len + 1);
                m_we = 1;
                m_adr = m_pos;
                m_wcount++;
                if (m_pos == m_len) begin
                    m_rst = 1;
                    m_bc = (m_wcount / (m_len + 1)) % 65536;
                    if (m_irq) m_ovr = 1;
                    m_set = 1;
                    if (!m_cont) m_mode = 3;
                end else begin
                    m_en = 1;
                end
            end
            if (m_set) m_irq = 1;
            else if (irq_ack) m_irq = 0;
            m_busy = (m_mode == 1 || m_mode == 2);
        end
    end

    function automatic logic [34:0] dut_vec();
        return {r_enable, r_reset, rxb0_we, rxb0_adr, busy, irq, overrun, block_count, state};
    endfunction

    function automatic logic [34:0] mdl_vec();
        return {m_en, m_rst, m_we, DL'(m_adr), m_busy, m_irq, m_ovr, 16'(m_bc), 2'(m_mode)};
    endfunction

    task automatic tick();
        @(posedge rxb0_clk);
        @(negedge rxb0_clk);
    endtask

    task automatic go_idle();
        abort = 1; start = 0; sample_valid = 0; irq_ack = 0;
        tick();
        abort = 0;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rxb0_rst_n = 0;
        tick(); tick();
        n_cmp++;
        if (dut_vec() !== 35'd0) begin
            n_err++; $display("FAIL reset_outputs: got %h expected 0", dut_vec());
        end
        rxb0_rst_n = 1;
        tick();
        n_cmp++;
        if (dut_vec() !== mdl_vec()) begin
            n_err++; $display("FAIL reset_release: got %h expected %h", dut_vec(), mdl_vec());
        end
    endtask

    task automatic test_single_shot();
        int q[$];
        length = 3; continuous = 0; use_trigger = 0; start = 1; irq_ack = 1;
        tick();
        start = 0; irq_ack = 0;
        n_cmp++;
        if (r_reset !== 1'b1 || state !== 2'd1 || busy !== 1'b1) begin
            n_err++; $display("FAIL single_arm: r_reset=%b state=%0d busy=%b expected 1 1 1", r_reset, state, busy);
        end
        sample_valid = 1;
        for (int i = 0; i < 10; i++) begin
            tick();
            n_cmp++;
            if (dut_vec() !== mdl_vec()) begin
                n_err++; $display("FAIL single_vec: got %h expected %h", dut_vec(), mdl_vec());
            end
            if (rxb0_we === 1'b1) begin
                q.push_back(int'(rxb0_adr));
                if (rxb0_adr == 3) begin
                    n_cmp++;
                    if (r_reset !== 1'b1 || r_enable !== 1'b0) begin
                        n_err++; $display("FAIL single_last_strobe: r_reset=%b r_enable=%b expected 1 0", r_reset, r_enable);
                    end
                end
            end
        end
        n_cmp++;
        if (q.size() != 4 || q[0] != 0 || q[1] != 1 || q[2] != 2 || q[3] != 3) begin
            n_err++; $display("FAIL single_addrs: got %0d writes (%p) expected 0,1,2,3", q.size(), q);
        end
        n_cmp++;
        if (irq !== 1'b1 || state !== 2'd3 || block_count !== 16'd1) begin
            n_err++; $display("FAIL single_done: irq=%b state=%0d bc=%0d expected 1 3 1", irq, state, block_count);
        end
        sample_valid = 0;
    endtask

    task automatic test_trigger_wait();
        int writes = 0;
        trigger = 0; length = DL'($urandom_range(1, 9)); continuous = 0; use_trigger = 1;
        start = 1; irq_ack = 1;
        tick();
        start = 0; irq_ack = 0;
        for (int i = 0; i < 20; i++) begin
            sample_valid = ($urandom_range(0, 3) != 0);
            tick();
            n_cmp++;
            if (dut_vec() !== mdl_vec()) begin
                n_err++; $display("FAIL trig_wait_vec: got %h expected %h", dut_vec(), mdl_vec());
            end
            if (rxb0_we === 1'b1) writes++;
        end
        n_cmp++;
        if (writes != 0 || busy !== 1'b1) begin
            n_err++; $display("FAIL trig_wait_idle: writes=%0d busy=%b expected 0 1", writes, busy);
        end
        trigger = 1; sample_valid = 1;
        tick();
        n_cmp++;
        if (rxb0_we !== 1'b0 || state !== 2'd2) begin
            n_err++; $display("FAIL trig_edge_cap: we=%b state=%0d expected 0 2", rxb0_we, state);
        end
        tick();
        n_cmp++;
        if (rxb0_we !== 1'b1 || rxb0_adr !== '0) begin
            n_err++; $display("FAIL trig_first_write: we=%b adr=%0d expected 1 0", rxb0_we, rxb0_adr);
        end
        trigger = 0;
        go_idle();
    endtask

    task automatic test_ring(input bit with_ack);
        int q[$];
        int budget = 0;
        length = 7; continuous = 1; use_trigger = 0; start = 1; irq_ack = 1;
        tick();
        start = 0; irq_ack = 0;
        while (q.size() < 24 && budget < 400) begin
            sample_valid = (m_wcount < 24) && ($urandom_range(0, 3) != 0);
            irq_ack = with_ack && (irq === 1'b1);
            tick();
            budget++;
            n_cmp++;
            if (dut_vec() !== mdl_vec()) begin
                n_err++; $display("FAIL ring_vec: got %h expected %h", dut_vec(), mdl_vec());
            end
            if (rxb0_we === 1'b1) q.push_back(int'(rxb0_adr));
        end
        sample_valid = 0; irq_ack = 0;
        n_cmp++;
        if (q.size() != 24) begin
            n_err++; $display("FAIL ring_timeout: got %0d writes expected 24", q.size());
        end
        for (int i = 0; i < q.size(); i++) begin
            n_cmp++;
            if (q[i] != i % 8) begin
                n_err++; $display("FAIL ring_addr: write %0d got %0d expected %0d", i, q[i], i % 8);
            end
        end
        n_cmp++;
        if (block_count !== 16'd3 || overrun !== !with_ack || irq !== 1'b1) begin
            n_err++; $display("FAIL ring_flags: bc=%0d overrun=%b irq=%b expected 3 %b 1", block_count, overrun, irq, !with_ack);
        end
        go_idle();
    endtask

    task automatic test_abort();
        int writes = 0;
        int budget = 0;
        length = 15; continuous = 0; use_trigger = 0; start = 1; irq_ack = 1;
        tick();
        start = 0; irq_ack = 0; sample_valid = 1;
        while (writes < 5 && budget < 50) begin
            tick();
            budget++;
            if (rxb0_we === 1'b1) writes++;
        end
        n_cmp++;
        if (writes != 5) begin
            n_err++; $display("FAIL abort_setup: got %0d writes expected 5", writes);
        end
        abort = 1;
        tick();
        abort = 0;
        n_cmp++;
        if (state !== 2'd0 || rxb0_we !== 1'b0 || r_enable !== 1'b0 || irq !== 1'b0) begin
            n_err++; $display("FAIL abort_idle: state=%0d we=%b en=%b irq=%b expected 0 0 0 0", state, rxb0_we, r_enable, irq);
        end
        writes = 0;
        for (int i = 0; i < 6; i++) begin
            sample_valid = $urandom_range(0, 1);
            tick();
            if (rxb0_we === 1'b1) writes++;
        end
        n_cmp++;
        if (writes != 0 || irq !== 1'b0) begin
            n_err++; $display("FAIL abort_quiet: writes=%0d irq=%b expected 0 0", writes, irq);
        end
        start = 1;
        tick();
        start = 0;
        n_cmp++;
        if (r_reset !== 1'b1) begin
            n_err++; $display("FAIL abort_restart_reset: r_reset=%b expected 1", r_reset);
        end
        sample_valid = 1;
        budget = 0;
        while (rxb0_we !== 1'b1 && budget < 10) begin
            tick();
            budget++;
        end
        n_cmp++;
        if (rxb0_we !== 1'b1 || rxb0_adr !== '0) begin
            n_err++; $display("FAIL abort_restart_adr: we=%b adr=%0d expected 1 0", rxb0_we, rxb0_adr);
        end
        go_idle();
    endtask

    task automatic test_collisions();
        int writes = 0;
        abort = 1; start = 1; length = 4; continuous = 0; use_trigger = 0;
        tick();
        abort = 0; start = 0;
        n_cmp++;
        if (state !== 2'd0 || r_reset !== 1'b0 || busy !== 1'b0) begin
            n_err++; $display("FAIL abort_start: state=%0d r_reset=%b busy=%b expected 0 0 0", state, r_reset, busy);
        end
        // length 0, ring mode, irq_ack held: each write is a block end
        length = 0; continuous = 1; start = 1; irq_ack = 1;
        tick();
        start = 0;
        for (int i = 0; i < 40; i++) begin
            sample_valid = $urandom_range(0, 1);
            tick();
            n_cmp++;
            if (dut_vec() !== mdl_vec()) begin
                n_err++; $display("FAIL len0_vec: got %h expected %h", dut_vec(), mdl_vec());
            end
            if (rxb0_we === 1'b1) begin
                writes++;
                n_cmp++;
                if (rxb0_adr !== '0 || r_reset !== 1'b1 || r_enable !== 1'b0 || irq !== 1'b1) begin
                    n_err++; $display("FAIL len0_write: adr=%0d rst=%b en=%b irq=%b expected 0 1 0 1", rxb0_adr, r_reset, r_enable, irq);
                end
            end
        end
        n_cmp++;
        if (writes == 0 || block_count !== 16'(writes)) begin
            n_err++; $display("FAIL len0_count: bc=%0d expected %0d (nonzero)", block_count, writes);
        end
        go_idle();
    endtask

    task automatic test_wrap_2047();
        int prev = -1;
        bit seen_wrap = 0;
        int budget = 0;
        length = DL'(2047); continuous = 1; use_trigger = 0; start = 1; irq_ack = 1;
        tick();
        start = 0; irq_ack = 0;
        while (!seen_wrap && budget < 3000) begin
            sample_valid = ($urandom_range(0, 7) != 0);
            tick();
            budget++;
            n_cmp++;
            if (dut_vec() !== mdl_vec()) begin
                n_err++; $display("FAIL wrap_vec: got %h expected %h", dut_vec(), mdl_vec());
            end
            if (rxb0_we === 1'b1) begin
                if (prev == 2047) begin
                    seen_wrap = 1;
                    n_cmp++;
                    if (rxb0_adr !== '0 || block_count !== 16'd1) begin
                        n_err++; $display("FAIL wrap_adr: adr=%0d bc=%0d expected 0 1", rxb0_adr, block_count);
                    end
                end
                prev = int'(rxb0_adr);
            end
        end
        n_cmp++;
        if (!seen_wrap) begin
            n_err++; $display("FAIL wrap_timeout: last adr %0d expected wrap 2047->0", prev);
        end
        go_idle();
    endtask

    task automatic test_reset_mid();
        length = 15; continuous = 1; use_trigger = 0; start = 1; irq_ack = 1;
        tick();
        start = 0; irq_ack = 0; sample_valid = 1;
        for (int i = 0; i < 6; i++) tick();
        rxb0_rst_n = 0;
        tick();
        n_cmp++;
        if (dut_vec() !== 35'd0) begin
            n_err++; $display("FAIL reset_mid: got %h expected 0", dut_vec());
        end
        rxb0_rst_n = 1; sample_valid = 0;
        tick();
        n_cmp++;
        if (dut_vec() !== mdl_vec()) begin
            n_err++; $display("FAIL reset_mid_after: got %h expected %h", dut_vec(), mdl_vec());
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            start        = ($urandom_range(0, 19) == 0);
            abort        = ($urandom_range(0, 39) == 0);
            irq_ack      = ($urandom_range(0, 7) == 0);
            sample_valid = $urandom_range(0, 1);
            if ($urandom_range(0, 9) == 0) trigger = ~trigger;
            length       = DL'($urandom_range(0, 5));
            continuous   = $urandom_range(0, 1);
            use_trigger  = $urandom_range(0, 1);
            rxb0_rst_n   = ($urandom_range(0, 199) != 0);
            tick();
            n_cmp++;
            if (dut_vec() !== mdl_vec()) begin
                n_err++; $display("FAIL random_vec: cycle %0d got %h expected %h", i, dut_vec(), mdl_vec());
            end
        end
        rxb0_rst_n = 1;
        go_idle();
    endtask

    initial begin
        rxb0_rst_n = 0; start = 0; abort = 0; continuous = 0; use_trigger = 0;
        trigger = 0; length = '0; sample_valid = 0; irq_ack = 0;
        test_reset();
        test_single_shot();
        test_trigger_wait();
        test_ring(1'b0);
        test_ring(1'b1);
        test_abort();
        test_collisions();
        test_wrap_2047();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/gpsreceiver2_capture_ctl.md
# gpsreceiver2_capture_ctl

Capture sequencer for the GPS-SDR sample buffer. Arms on a start command, optionally waits for a 1PPS rising edge, then steers the sample-address counter (`r_enable`/`r_reset`) and buffer write port for a programmed number of samples. It runs single-shot or continuous ring mode, raises a per-block interrupt, and flags overruns. It sits between the CSR/control logic and the address counter / sample RAM on the receiver clock.

## Interface
- `DEPTH_LOG2`, 11, buffer address width; all address/length fields use this width
- `rxb0_clk`  in  1  receiver clock; the only clock
- `rxb0_rst_n`  in  1  synchronous, active-low reset
- `start`  in  1  one-cycle command: arm capture; latches `length`, `continuous`, `use_trigger`
- `abort`  in  1  one-cycle command: return to IDLE
- `continuous`  in  1  0 = single-shot, 1 = ring mode
- `use_trigger`  in  1  1 = wait for 1PPS rising edge before capturing
- `trigger`  in  1  1PPS level, synchronous to `rxb0_clk`
- `length`  in  DEPTH_LOG2  last address of the block; a block is `length`+1 samples
- `sample_valid`  in  1  ADC sample strobe
- `irq_ack`  in  1  one-cycle interrupt clear
- `r_enable`  out  1  increment strobe to the address counter
- `r_reset`  out  1  clear strobe to the address counter
- `rxb0_we`  out  1  buffer write enable
- `rxb0_adr`  out  DEPTH_LOG2  buffer write address
- `busy`  out  1  state is ARMED or CAPTURE
- `irq`  out  1  block-complete interrupt, level, sticky
- `overrun`  out  1  sticky: a block completed while `irq` was still pending
- `block_count`  out  16  completed blocks since the last `start`; wraps at 0xFFFF→0
- `state`  out  2  IDLE=0, ARMED=1, CAPTURE=2, DONE=3

## Operation
- **Registers.** All outputs are registered. Reset (`rxb0_rst_n`=0 on a clock edge) forces state IDLE and every output to 0, including `rxb0_adr`, `block_count`, and the internal `cnt`/`trig_prev`. Reset takes effect mid-capture too.
- **Edge detect.** `trig_edge` = `trigger` & ~`trig_prev`; `trig_prev` updates every cycle. If `trigger` is high at reset release, no edge is seen until it goes low and then high.
- **IDLE.**
  - On `start`: latch the config, clear `cnt`, `overrun` and `block_count`, pulse `r_reset` for one cycle, go to ARMED.
- **ARMED.**
  - With `use_trigger`=0: go to CAPTURE on the next edge.
  - With `use_trigger`=1: stay until `trig_edge`, then go to CAPTURE.
  - `sample_valid` is ignored in ARMED, including on the edge cycle itself.
- **CAPTURE.** For each `sample_valid` cycle:
  - Next cycle: `rxb0_we`=1, `rxb0_adr`=`cnt`.
  - If `cnt`≠length_l: `r_enable`=1, `r_reset`=0, `cnt`++.
  - If `cnt`=length_l (block end): `r_enable`=0, `r_reset`=1, `cnt`←0, `block_count`++, `irq`←1.
    - If `irq` was already 1, also set `overrun`←1.
    - Single-shot: go to DONE. Continuous: stay in CAPTURE.
  - Cycles without `sample_valid` leave `rxb0_we`, `r_enable` and `r_reset` at 0.
- **DONE.** Holds with no writes. On `start`, re-arm exactly as from IDLE.
- **Ignored commands.** `start` while in ARMED or CAPTURE is ignored. `irq_ack` only clears `irq`.
- **Abort.** `abort` in any state goes to IDLE next cycle; no strobes are issued that cycle and `irq` is not raised. If `abort` and `start` arrive together, `abort` wins.
- **Interrupt priority.** If an `irq` set and `irq_ack` occur in the same cycle, the set wins.
- **Length 0.** Every sample is a block end: `r_reset` on every write, `rxb0_adr` stays 0.

## Timing
- **Start to capture, no trigger.** `start` at cycle N: ARMED at N+1, `r_reset`=1 during N+1, CAPTURE at N+2. The first accepted `sample_valid` is at N+2, with the write at N+3.
- **Trigger.** `trig_edge` at cycle T (state ARMED) gives CAPTURE at T+1.
- **Write latency.** `sample_valid` to `rxb0_we`/`rxb0_adr`/`r_enable` is 1 cycle. Back-to-back `sample_valid` gives one write per cycle with consecutive addresses.
- **Counter agreement.** The external counter sees `r_enable`/`r_reset` on the same edge as the write, so its value equals `rxb0_adr` of the next write.
- **Block end.** `irq`, `block_count` and `state`=DONE all update on the same edge as the final write.

## Test plan
- **Single-shot.** `length`=3, no trigger, `start`, `sample_valid` held high → writes at addresses 0,1,2,3; `r_reset` with the address-3 write; `irq`=1, `state`=3, `block_count`=1; further `sample_valid` produces no writes.
- **Trigger wait.** `use_trigger`=1, `trigger` low, samples flowing for 20 cycles → no writes, `busy`=1. Raise `trigger` → first write (adr 0) occurs 2 cycles after the edge.
- **Ring with overrun.** `continuous`=1, `length`=7, 24 samples, no `irq_ack` → addresses 0..7 repeated 3×, `block_count`=3, `overrun`=1. Repeat with `irq_ack` after each block → `overrun`=0.
- **Abort mid-capture.** Abort after 5 writes (`length`=15) → `state`=0 next cycle, no further writes, `irq`=0. Then `start` → `r_reset` pulse, and writes restart at adr 0.
- **Collisions and boundaries.**
  - `abort`+`start` same cycle → IDLE.
  - `irq_ack` on the block-end cycle → `irq` stays 1.
  - `length`=0 → every write at adr 0 with `r_reset`=1.
  - `length`=2047 → wrap from 2047 to 0.
- **Reset mid-capture.** `rxb0_rst_n`=0 for one edge during CAPTURE → all outputs 0, `state`=0, `block_count`=0.
